// File: rtl/sync_set_reset_dff.sv
// WIDTH-bit, STAGES-deep D register with synchronous reset/set priority and a
// shared clock enable; Q is the last stage and Qbar its complement.
module sync_set_reset_dff #(
  parameter int unsigned          WIDTH     = 1,
  parameter int unsigned          STAGES    = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0]     SET_VAL   = {WIDTH{1'b1}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set,
  input  logic             enable,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar
);

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_set_reset_dff: WIDTH must be >= 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("sync_set_reset_dff: STAGES must be >= 1");
  end

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  // Set and enable are resolved here; reset is applied in the register so it
  // always dominates regardless of the other controls.
  always_comb begin
    stage_d = stage_q;
    if (set) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_d[i] = SET_VAL;
      end
    end else if (enable) begin
      stage_d[0] = D;
      for (int i = 1; i < STAGES; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q <= {STAGES{RESET_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign Q    = stage_q[STAGES-1];
  assign Qbar = ~stage_q[STAGES-1];

endmodule

// File: tb/tb_sync_set_reset_dff.sv
// Directed bench: a default single flop and an 8-bit, 3-stage delay line
// share one clock; inputs change on the falling edge, outputs are checked
// 1 time unit after the rising edge.
module tb_sync_set_reset_dff;

  logic       clk;
  logic       r1, s1, e1, d1;
  logic       q1, qb1;
  logic       r8, s8, e8;
  logic [7:0] d8, q8, qb8;

  int checks   = 0;
  int failures = 0;

  sync_set_reset_dff u_dff1 (
    .clock (clk),
    .reset (r1),
    .set   (s1),
    .enable(e1),
    .D     (d1),
    .Q     (q1),
    .Qbar  (qb1)
  );

  sync_set_reset_dff #(
    .WIDTH (8),
    .STAGES(3)
  ) u_dff8 (
    .clock (clk),
    .reset (r8),
    .set   (s8),
    .enable(e8),
    .D     (d8),
    .Q     (q8),
    .Qbar  (qb8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive1(input logic r, input logic s, input logic e, input logic d);
    @(negedge clk);
    r1 = r; s1 = s; e1 = e; d1 = d;
  endtask

  task automatic drive8(input logic r, input logic s, input logic e, input logic [7:0] d);
    @(negedge clk);
    r8 = r; s8 = s; e8 = e; d8 = d;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic exp_q);
    checks++;
    assert (q1 === exp_q) else begin
      failures++;
      $error("FAIL %s: Q observed=%b expected=%b", tag, q1, exp_q);
    end
    checks++;
    assert (qb1 === ~exp_q) else begin
      failures++;
      $error("FAIL %s_qbar: Qbar observed=%b expected=%b", tag, qb1, ~exp_q);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] exp_q);
    checks++;
    assert (q8 === exp_q) else begin
      failures++;
      $error("FAIL %s: Q observed=%h expected=%h", tag, q8, exp_q);
    end
    checks++;
    assert (qb8 === ~exp_q) else begin
      failures++;
      $error("FAIL %s_qbar: Qbar observed=%h expected=%h", tag, qb8, ~exp_q);
    end
  endtask

  initial begin
    r1 = 1'b0; s1 = 1'b0; e1 = 1'b0; d1 = 1'b0;
    r8 = 1'b0; s8 = 1'b0; e8 = 1'b0; d8 = 8'h00;

    // ---------------- single flop ----------------
    drive1(1'b1, 1'b0, 1'b0, 1'b0); edge_wait(); check1("w1_reset", 1'b0);
    drive1(1'b0, 1'b0, 1'b1, 1'b1); edge_wait(); check1("w1_d1", 1'b1);
    drive1(1'b0, 1'b0, 1'b1, 1'b0); edge_wait(); check1("w1_d0", 1'b0);
    drive1(1'b0, 1'b0, 1'b1, 1'b1); edge_wait(); check1("w1_d1b", 1'b1);
    drive1(1'b0, 1'b0, 1'b1, 1'b0); edge_wait(); check1("w1_d0b", 1'b0);

    // set with D=0: no change until the edge, then Q=1
    drive1(1'b0, 1'b1, 1'b1, 1'b0); #1; check1("w1_set_pre_edge", 1'b0);
    edge_wait(); check1("w1_set", 1'b1);
    drive1(1'b0, 1'b0, 1'b1, 1'b0); edge_wait(); check1("w1_after_set", 1'b0);
    drive1(1'b0, 1'b0, 1'b1, 1'b1); edge_wait(); check1("w1_pre_both", 1'b1);

    // reset beats set
    drive1(1'b1, 1'b1, 1'b1, 1'b1); edge_wait(); check1("w1_reset_over_set", 1'b0);
    drive1(1'b0, 1'b0, 1'b1, 1'b1); edge_wait(); check1("w1_release", 1'b1);

    // enable low holds Q while D toggles
    drive1(1'b0, 1'b0, 1'b0, 1'b0); edge_wait(); check1("w1_hold0", 1'b1);
    drive1(1'b0, 1'b0, 1'b0, 1'b1); edge_wait(); check1("w1_hold1", 1'b1);
    drive1(1'b0, 1'b0, 1'b0, 1'b0); edge_wait(); check1("w1_hold2", 1'b1);

    // set and reset act even with enable low
    drive1(1'b1, 1'b0, 1'b0, 1'b1); edge_wait(); check1("w1_reset_no_en", 1'b0);
    drive1(1'b0, 1'b1, 1'b0, 1'b0); edge_wait(); check1("w1_set_no_en", 1'b1);

    // ---------------- 8-bit, 3-stage delay line ----------------
    drive8(1'b1, 1'b0, 1'b0, 8'hFF); edge_wait(); check8("w8_reset", 8'h00);
    drive8(1'b0, 1'b0, 1'b1, 8'hA5); edge_wait(); check8("w8_lat_k", 8'h00);
    drive8(1'b0, 1'b0, 1'b1, 8'h3C); edge_wait(); check8("w8_lat_k1", 8'h00);
    drive8(1'b0, 1'b0, 1'b1, 8'h0F); edge_wait(); check8("w8_lat_k2", 8'hA5);
    edge_wait(); check8("w8_lat_k3", 8'h3C);
    edge_wait(); check8("w8_lat_k4", 8'h0F);

    // flush: A5 enters at k, reset at k+1, A5 must never reach Q
    drive8(1'b0, 1'b0, 1'b1, 8'hA5); edge_wait(); check8("w8_flush_k", 8'h0F);
    drive8(1'b1, 1'b0, 1'b1, 8'h11); edge_wait(); check8("w8_flush_k1", 8'h00);
    drive8(1'b0, 1'b0, 1'b1, 8'h11); edge_wait(); check8("w8_flush_k2", 8'h00);
    edge_wait(); check8("w8_flush_k3", 8'h00);
    edge_wait(); check8("w8_flush_k4", 8'h11);

    // freeze: pipeline holds {22,11,11}, no bubble appears on restart
    drive8(1'b0, 1'b0, 1'b1, 8'h22); edge_wait(); check8("w8_fill", 8'h11);
    drive8(1'b0, 1'b0, 1'b0, 8'h33); edge_wait(); check8("w8_freeze0", 8'h11);
    edge_wait(); check8("w8_freeze1", 8'h11);
    drive8(1'b0, 1'b0, 1'b1, 8'h33); edge_wait(); check8("w8_resume0", 8'h11);
    edge_wait(); check8("w8_resume1", 8'h22);
    edge_wait(); check8("w8_resume2", 8'h33);

    // set fills every stage, reset wins over set
    drive8(1'b0, 1'b1, 1'b1, 8'h44); edge_wait(); check8("w8_set", 8'hFF);
    drive8(1'b1, 1'b1, 1'b1, 8'h44); edge_wait(); check8("w8_reset_over_set", 8'h00);
    drive8(1'b0, 1'b1, 1'b0, 8'h44); edge_wait(); check8("w8_set_no_en", 8'hFF);
    drive8(1'b0, 1'b0, 1'b1, 8'h55); edge_wait(); check8("w8_after_set0", 8'hFF);
    edge_wait(); check8("w8_after_set1", 8'hFF);
    edge_wait(); check8("w8_after_set2", 8'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
